// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the mode-0 SPI initiator
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } spi_state_t;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_SETUP  = SETUP;
  localparam logic [2:0] ST_SCK_HI = SCK_HI;
  localparam logic [2:0] ST_SCK_LO = SCK_LO;
  localparam logic [2:0] ST_HOLD   = HOLD;
  localparam logic [2:0] ST_DONE   = DONE;

  localparam int SPI_MODE    = 0;
  localparam int CLK_DIV_MIN = 1;
  localparam int CLK_DIV_MAX = 255;
  localparam int DIV_CNT_W   = $clog2(CLK_DIV_MAX + 1);

  function automatic bit clk_div_legal(input int div);
    return (div >= CLK_DIV_MIN) && (div <= CLK_DIV_MAX);
  endfunction

endpackage

// File: rtl/spi_if.sv
// rtl/spi_if.sv - core handshake plus SPI pins for the SPI initiator
interface spi_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              keep_cs;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic              cs_n;

  modport master (
    input  start, tx_data, keep_cs, miso,
    output rx_data, busy, done, sck, mosi, cs_n
  );

  modport slave (
    output start, tx_data, keep_cs, miso,
    input  rx_data, busy, done, sck, mosi, cs_n
  );
endinterface

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - SCK half-period down-counter, reloaded on every state entry
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick,
  output logic first
);

  localparam logic [DIV_CNT_W-1:0] RELOAD = DIV_CNT_W'(CLK_DIV - 1);

  logic [DIV_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // first marks the entry cycle of a state since every entry reloads the counter
  assign tick  = (count == '0);
  assign first = (count == RELOAD);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 MSB-first SPI initiator with byte start/done handshake
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic clk,
  input  logic reset,
  spi_if.master bus
);

  localparam int BIT_W = $clog2(DATA_W + 1);

  if (!clk_div_legal(CLK_DIV) || SPI_MODE != 0) begin : g_param_check
    $error("spi_master: CLK_DIV out of range or unsupported SPI mode");
  end

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic              keep_q;
  logic              cs_act;
  logic              tick;
  logic              first;
  logic              load;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .tick  (tick),
    .first (first)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_SETUP;
      ST_SETUP:  if (tick) state_nxt = ST_SCK_HI;
      ST_SCK_HI: if (tick) state_nxt = ST_SCK_LO;
      ST_SCK_LO: if (tick) state_nxt = (bit_cnt != '0) ? ST_SCK_HI : ST_HOLD;
      ST_HOLD:   if (tick) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign load = (state_nxt != state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_q    <= '0;
      bit_cnt <= '0;
      keep_q  <= 1'b0;
      cs_act  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && bus.start) begin
        tx_sr   <= bus.tx_data;
        keep_q  <= bus.keep_cs;
        bit_cnt <= BIT_W'(DATA_W);
        cs_act  <= 1'b1;
      end
      // miso is launched by the slave on the falling edge, so it is stable while sck is high
      if (state == ST_SCK_HI && first) begin
        rx_sr <= {rx_sr[DATA_W-2:0], bus.miso};
      end
      // Shift on the SCK_LO entry edge so mosi changes together with the falling edge
      if (state == ST_SCK_HI && tick) begin
        tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (state == ST_HOLD && tick) begin
        rx_q   <= rx_sr;
        cs_act <= keep_q;
      end
    end
  end

  assign bus.sck     = (state == ST_SCK_HI);
  assign bus.mosi    = (state == ST_IDLE) ? 1'b0 : tx_sr[DATA_W-1];
  assign bus.cs_n    = ~cs_act;
  assign bus.busy    = (state == ST_SETUP) || (state == ST_SCK_HI) ||
                       (state == ST_SCK_LO) || (state == ST_HOLD);
  assign bus.done    = (state == ST_DONE);
  assign bus.rx_data = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed bench: three initiators (CLK_DIV 2/4/1) on shared stimulus
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       keep_cs = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  spi_if #(.DATA_W(8)) if2 ();
  spi_if #(.DATA_W(8)) if4 ();
  spi_if #(.DATA_W(8)) if1 ();

  assign if2.start = start;  assign if2.tx_data = tx_data;  assign if2.keep_cs = keep_cs;
  assign if4.start = start;  assign if4.tx_data = tx_data;  assign if4.keep_cs = keep_cs;
  assign if1.start = start;  assign if1.tx_data = tx_data;  assign if1.keep_cs = keep_cs;

  logic [7:0] slave_sr;
  logic       slave_sck_p = 1'b0;
  assign if2.miso = if2.mosi;
  assign if1.miso = if1.mosi;
  assign if4.miso = slave_sr[7];

  spi_master #(.CLK_DIV(2), .DATA_W(8)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  spi_master #(.CLK_DIV(4), .DATA_W(8)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  spi_master #(.CLK_DIV(1), .DATA_W(8)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  // Slave on the CLK_DIV=4 instance: preloads 0x3C while deselected, shifts after each falling sck
  always @(posedge clk) begin
    if (if4.cs_n === 1'b1) slave_sr <= 8'h3C;
    else if (slave_sck_p && !if4.sck) slave_sr <= slave_sr << 1;
    slave_sck_p <= if4.sck;
  end

  wire [2:0] sck_v  = {if1.sck, if4.sck, if2.sck};
  wire [2:0] mosi_v = {if1.mosi, if4.mosi, if2.mosi};
  wire [2:0] done_v = {if1.done, if4.done, if2.done};
  wire [2:0] busy_v = {if1.busy, if4.busy, if2.busy};
  wire [2:0] cs_v   = {if1.cs_n, if4.cs_n, if2.cs_n};
  logic [7:0] rx_v [3];
  assign rx_v[0] = if2.rx_data;
  assign rx_v[1] = if4.rx_data;
  assign rx_v[2] = if1.rx_data;

  int rises [3] = '{0, 0, 0};
  int mosi_rise [3] = '{0, 0, 0};
  int hicyc [3] = '{0, 0, 0};
  int dones [3] = '{0, 0, 0};
  int busyc [3] = '{0, 0, 0};
  int cs_rises [3] = '{0, 0, 0};
  logic [2:0] sck_p = 3'b000;
  logic [2:0] cs_p = 3'b111;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sck_v[i] === 1'b1 && sck_p[i] === 1'b0) begin
        rises[i]++;
        if (mosi_v[i] === 1'b1) mosi_rise[i]++;
      end
      if (sck_v[i] === 1'b1) hicyc[i]++;
      if (done_v[i] === 1'b1) dones[i]++;
      if (busy_v[i] === 1'b1) busyc[i]++;
      if (cs_v[i] === 1'b1 && cs_p[i] === 1'b0) cs_rises[i]++;
    end
    sck_p = sck_v;
    cs_p  = cs_v;
  end

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; start = 1'b0; keep_cs = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic kc);
    @(negedge clk);
    tx_data = tx; keep_cs = kc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int w, input int n0, output int n);
    n = n0;
    while (done_v[w] !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    do_reset();
    total_cnt++; if (if2.sck !== 1'b0) $display("FAIL reset_sck got %b want 0", if2.sck); else pass_cnt++;
    total_cnt++; if (if2.mosi !== 1'b0) $display("FAIL reset_mosi got %b want 0", if2.mosi); else pass_cnt++;
    total_cnt++; if (if2.cs_n !== 1'b1) $display("FAIL reset_cs_n got %b want 1", if2.cs_n); else pass_cnt++;
    total_cnt++; if (if2.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", if2.busy); else pass_cnt++;
    total_cnt++; if (if2.done !== 1'b0) $display("FAIL reset_done got %b want 0", if2.done); else pass_cnt++;
    total_cnt++; if (if2.rx_data !== 8'h00) $display("FAIL reset_rx got %h want 00", if2.rx_data); else pass_cnt++;
  endtask

  task automatic test_loopback;
    int n, r, d;
    do_reset();
    r = rises[0]; d = dones[0];
    start_xfer(8'hA5, 1'b0);
    wait_done(0, 1, n);
    total_cnt++; if (n !== 37) $display("FAIL loop_latency got %0d want 37", n); else pass_cnt++;
    total_cnt++; if (if2.rx_data !== 8'hA5) $display("FAIL loop_rx got %h want a5", if2.rx_data); else pass_cnt++;
    total_cnt++; if (if2.cs_n !== 1'b1) $display("FAIL loop_cs_at_done got %b want 1", if2.cs_n); else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    total_cnt++; if (rises[0] - r !== 8) $display("FAIL loop_rises got %0d want 8", rises[0] - r); else pass_cnt++;
    total_cnt++; if (dones[0] - d !== 1) $display("FAIL loop_dones got %0d want 1", dones[0] - d); else pass_cnt++;
  endtask

  task automatic test_slave_rx;
    int n, r, m, b;
    do_reset();
    r = rises[1]; m = mosi_rise[1]; b = busyc[1];
    start_xfer(8'hFF, 1'b0);
    wait_done(1, 1, n);
    total_cnt++; if (n !== 73) $display("FAIL slave_latency got %0d want 73", n); else pass_cnt++;
    total_cnt++; if (if4.rx_data !== 8'h3C) $display("FAIL slave_rx got %h want 3c", if4.rx_data); else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    total_cnt++; if (rises[1] - r !== 8) $display("FAIL slave_rises got %0d want 8", rises[1] - r); else pass_cnt++;
    total_cnt++; if (mosi_rise[1] - m !== 8) $display("FAIL slave_mosi_high got %0d want 8", mosi_rise[1] - m); else pass_cnt++;
    total_cnt++; if (busyc[1] - b !== 72) $display("FAIL slave_busy_cycles got %0d want 72", busyc[1] - b); else pass_cnt++;
  endtask

  task automatic test_start_ignored;
    int n, d;
    do_reset();
    d = dones[0];
    start_xfer(8'hC3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    tx_data = 8'h11; keep_cs = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 11, n);
    total_cnt++; if (n !== 37) $display("FAIL ign_latency got %0d want 37", n); else pass_cnt++;
    total_cnt++; if (if2.rx_data !== 8'hC3) $display("FAIL ign_rx got %h want c3", if2.rx_data); else pass_cnt++;
    total_cnt++; if (if2.cs_n !== 1'b1) $display("FAIL ign_cs_at_done got %b want 1", if2.cs_n); else pass_cnt++;
    repeat (40) @(posedge clk); #1;
    total_cnt++; if (dones[0] - d !== 1) $display("FAIL ign_dones got %0d want 1", dones[0] - d); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int n, r, c;
    do_reset();
    r = rises[0]; c = cs_rises[0];
    start_xfer(8'h12, 1'b1);
    wait_done(0, 1, n);
    total_cnt++; if (n !== 37) $display("FAIL burst1_latency got %0d want 37", n); else pass_cnt++;
    total_cnt++; if (if2.rx_data !== 8'h12) $display("FAIL burst1_rx got %h want 12", if2.rx_data); else pass_cnt++;
    total_cnt++; if (if2.cs_n !== 1'b0) $display("FAIL burst1_cs_at_done got %b want 0", if2.cs_n); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (if2.cs_n !== 1'b0) $display("FAIL burst_cs_idle got %b want 0", if2.cs_n); else pass_cnt++;
    start_xfer(8'h34, 1'b0);
    wait_done(0, 1, n);
    total_cnt++; if (n !== 37) $display("FAIL burst2_latency got %0d want 37", n); else pass_cnt++;
    total_cnt++; if (if2.rx_data !== 8'h34) $display("FAIL burst2_rx got %h want 34", if2.rx_data); else pass_cnt++;
    total_cnt++; if (if2.cs_n !== 1'b1) $display("FAIL burst2_cs_at_done got %b want 1", if2.cs_n); else pass_cnt++;
    total_cnt++; if (cs_rises[0] - c !== 0) $display("FAIL burst_cs_glitch got %0d want 0", cs_rises[0] - c); else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    total_cnt++; if (rises[0] - r !== 16) $display("FAIL burst_rises got %0d want 16", rises[0] - r); else pass_cnt++;
    total_cnt++; if (cs_rises[0] - c !== 1) $display("FAIL burst_cs_rises got %0d want 1", cs_rises[0] - c); else pass_cnt++;
  endtask

  task automatic test_reset_abort;
    int n, r, d, k;
    r = rises[0]; d = dones[0]; k = 0;
    start_xfer(8'h77, 1'b0);
    while (rises[0] - r < 3 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    total_cnt++; if (k >= 200) $display("FAIL abort_wait got %0d rises want 3", rises[0] - r); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (if2.sck !== 1'b0) $display("FAIL abort_sck got %b want 0", if2.sck); else pass_cnt++;
    total_cnt++; if (if2.cs_n !== 1'b1) $display("FAIL abort_cs_n got %b want 1", if2.cs_n); else pass_cnt++;
    total_cnt++; if (if2.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", if2.busy); else pass_cnt++;
    total_cnt++; if (if2.rx_data !== 8'h00) $display("FAIL abort_rx got %h want 00", if2.rx_data); else pass_cnt++;
    total_cnt++; if (if2.done !== 1'b0) $display("FAIL abort_done got %b want 0", if2.done); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(posedge clk); #1;
    total_cnt++; if (dones[0] - d !== 0) $display("FAIL abort_no_done got %0d want 0", dones[0] - d); else pass_cnt++;
    start_xfer(8'h5A, 1'b0);
    wait_done(0, 1, n);
    total_cnt++; if (n !== 37) $display("FAIL abort_next_latency got %0d want 37", n); else pass_cnt++;
    total_cnt++; if (if2.rx_data !== 8'h5A) $display("FAIL abort_next_rx got %h want 5a", if2.rx_data); else pass_cnt++;
  endtask

  task automatic test_div1;
    int n, r, h;
    do_reset();
    r = rises[2]; h = hicyc[2];
    start_xfer(8'h80, 1'b0);
    wait_done(2, 1, n);
    total_cnt++; if (n !== 19) $display("FAIL div1_latency got %0d want 19", n); else pass_cnt++;
    total_cnt++; if (if1.rx_data !== 8'h80) $display("FAIL div1_rx got %h want 80", if1.rx_data); else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    total_cnt++; if (rises[2] - r !== 8) $display("FAIL div1_rises got %0d want 8", rises[2] - r); else pass_cnt++;
    total_cnt++; if (hicyc[2] - h !== 8) $display("FAIL div1_high_cycles got %0d want 8", hicyc[2] - h); else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback();
    test_slave_rx();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_div1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
